// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU-to-memory response controller: FSM state
// encoding, region decode bit and default ROM/RAM latencies.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROM_ACC = 2'd1,
    RAM_ACC = 2'd2,
    RESP    = 2'd3
  } state_e;

  // addr[REGION_BIT]=1 selects RAM, 0 selects ROM
  localparam int unsigned REGION_BIT  = 11;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned ROM_LAT_DEF = 1;
  localparam int unsigned RAM_LAT_DEF = 2;

endpackage

// File: rtl/mem_resp_ctrl.sv
// Single-outstanding CPU access controller in front of a ROM (addr[11]=0)
// and a RAM (addr[11]=1); one ack per accepted request, err on ROM writes.
module mem_resp_ctrl
  import mem_bus_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ROM_LAT = ROM_LAT_DEF,
  parameter int unsigned RAM_LAT = RAM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [11:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              rom_en,
  output logic              ram_en,
  output logic              ram_we,
  output logic [10:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] rom_rdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [CNT_W-1:0] ROM_CNT = CNT_W'(ROM_LAT - 1);
  localparam logic [CNT_W-1:0] RAM_CNT = CNT_W'(RAM_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              ram_sel_q, ram_sel_d;
  logic              err_q, err_d;
  logic              rom_en_q, rom_en_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [10:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    ram_sel_d   = ram_sel_q;
    err_d       = err_q;
    rom_en_d    = 1'b0;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;

    unique case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (req) begin
          we_d        = we;
          ram_sel_d   = addr[REGION_BIT];
          mem_addr_d  = addr[10:0];
          mem_wdata_d = wdata;
          if (addr[REGION_BIT]) begin
            state_d  = RAM_ACC;
            ram_en_d = 1'b1;
            ram_we_d = we;
            cnt_d    = RAM_CNT;
          end else if (we) begin
            // ROM is read-only: refuse immediately without touching memory
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d  = ROM_ACC;
            rom_en_d = 1'b1;
            cnt_d    = ROM_CNT;
          end
        end
      end
      ROM_ACC, RAM_ACC: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (!we_q) begin
            rdata_d = ram_sel_q ? ram_rdata : rom_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      ram_sel_q   <= 1'b0;
      err_q       <= 1'b0;
      rom_en_q    <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      ram_sel_q   <= ram_sel_d;
      err_q       <= err_d;
      rom_en_q    <= rom_en_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign ack       = (state_q == RESP);
  assign err       = ack & err_q;
  assign rdata     = rdata_q;
  assign rom_en    = rom_en_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Directed scoreboard bench for mem_resp_ctrl: main instance ROM_LAT=1/RAM_LAT=2,
// second instance RAM_LAT=4 for the mid-access reset case.
module tb_mem_resp_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        req4 = 1'b0;
  logic        we = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;

  logic        busy, ack, err, rom_en, ram_en, ram_we;
  logic [31:0] rdata, mem_wdata, rom_rdata, ram_rdata;
  logic [10:0] mem_addr;

  logic        busy4, ack4, err4, rom_en4, ram_en4, ram_we4;
  logic [31:0] rdata4, mem_wdata4, rom_rdata4;
  logic [10:0] mem_addr4;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  logic [31:0] ram_mem [2048];
  logic [31:0] exp_ram [int];
  logic [31:0] model_rdata = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rom_fn(input logic [10:0] a);
    return (a == 11'h004) ? 32'hDEAD_BEEF : {5'd0, a, 16'hA5C3};
  endfunction

  // Simple memory slaves: ROM is a fixed function of address, RAM is an array
  assign rom_rdata  = rom_fn(mem_addr);
  assign rom_rdata4 = rom_fn(mem_addr4);
  assign ram_rdata  = ram_mem[mem_addr];
  always @(posedge clk) if (ram_en && ram_we) ram_mem[mem_addr] <= mem_wdata;

  mem_resp_ctrl #(.DATA_W(32), .ROM_LAT(1), .RAM_LAT(2)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .ack(ack), .err(err), .rdata(rdata),
    .rom_en(rom_en), .ram_en(ram_en), .ram_we(ram_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rom_rdata(rom_rdata), .ram_rdata(ram_rdata)
  );

  mem_resp_ctrl #(.DATA_W(32), .ROM_LAT(1), .RAM_LAT(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy4), .ack(ack4), .err(err4), .rdata(rdata4),
    .rom_en(rom_en4), .ram_en(ram_en4), .ram_we(ram_we4),
    .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .rom_rdata(rom_rdata4), .ram_rdata(32'h0BAD_0BAD)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each ack of the main DUT
  always @(negedge clk) begin
    if (!rst) begin
      chk("err_without_ack", err & ~ack, 0);
      chk("rom_ram_both_en", rom_en & ram_en, 0);
      if (ack) begin
        chk("unexpected_ack", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_cycle", cyc, e.cyc);
          chk("ack_err", err, e.err);
          if (!e.err) chk("ack_rdata", rdata, e.rdata);
        end
      end
    end
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 32) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, busy, 0);
  endtask

  // Drive one request at a negedge; accept happens at the next posedge.
  // An ack is expected visible LAT cycles after the accept edge (sampled at
  // the LAT+1'th edge), LAT=0 for a refused ROM write.
  task automatic access(input logic w, input logic [11:0] a, input logic [31:0] d);
    int          lat;
    logic        is_err;
    logic [31:0] exp_rd;
    exp_t        e;
    is_err = !a[11] && w;
    lat    = a[11] ? 2 : (w ? 0 : 1);
    if (w) exp_rd = model_rdata;
    else   exp_rd = a[11] ? exp_ram[int'(a[10:0])] : rom_fn(a[10:0]);
    model_rdata = exp_rd;
    if (w && a[11]) exp_ram[int'(a[10:0])] = d;
    req = 1'b1; we = w; addr = a; wdata = d;
    e.cyc = cyc + 1 + lat; e.err = is_err; e.rdata = exp_rd;
    sb.push_back(e);
    @(negedge clk);
    req = 1'b0;
    chk("entry_busy", busy, 1);
    chk("entry_rom_en", rom_en, !a[11] && !w);
    chk("entry_ram_en", ram_en, a[11]);
    chk("entry_ram_we", ram_we, a[11] && w);
    chk("entry_mem_addr", mem_addr, a[10:0]);
    chk("entry_mem_wdata", mem_wdata, d);
    @(negedge clk);
    chk("strobe_one_cycle", {rom_en, ram_en, ram_we}, 0);
    wait_idle("access");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   k;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ctrl", {busy, ack, err, rom_en, ram_en, ram_we}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_ctrl4", {busy4, ack4, err4, rom_en4, ram_en4, ram_we4}, 0);

    access(1'b0, 12'h004, 32'h0);
    access(1'b1, 12'h810, 32'h1234_5678);
    access(1'b1, 12'h020, 32'h5555_AAAA);
    access(1'b0, 12'h810, 32'h0);
    access(1'b1, 12'hFFF, 32'hA5A5_0F0F);
    access(1'b0, 12'h7FF, 32'h0);
    access(1'b0, 12'hFFF, 32'h0);
    access(1'b1, 12'h800, 32'h0000_0001);

    // req held high: RAM read then ROM read, address changes while busy
    k = cyc;
    req = 1'b1; we = 1'b0; addr = 12'h810;
    e.cyc = k + 3; e.err = 1'b0; e.rdata = exp_ram[int'(11'h010)];
    sb.push_back(e);
    e.cyc = k + 6; e.err = 1'b0; e.rdata = rom_fn(11'h004);
    sb.push_back(e);
    model_rdata = e.rdata;
    @(negedge clk);
    addr = 12'h004;
    repeat (4) @(negedge clk);
    chk("b2b_second_accept", rom_en, 1);
    chk("b2b_second_addr", mem_addr, 11'h004);
    req = 1'b0;
    wait_idle("b2b");
    repeat (4) @(negedge clk);
    chk("b2b_sb_drained", sb.size(), 0);

    // Reset in cycle 2 of a RAM_LAT=4 read aborts without ack
    req4 = 1'b1; we = 1'b0; addr = 12'h810;
    @(negedge clk);
    req4 = 1'b0;
    chk("rst4_entry_ram_en", ram_en4, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_rdata = '0;
    chk("rst4_ctrl", {busy4, ack4, err4, rom_en4, ram_en4, ram_we4}, 0);
    chk("rst4_rdata", rdata4, 0);
    chk("rst4_mem_addr", mem_addr4, 0);
    chk("rst4_mem_wdata", mem_wdata4, 0);
    repeat (6) begin
      @(negedge clk);
      chk("rst4_no_ack", ack4, 0);
    end
    req4 = 1'b1; we = 1'b0; addr = 12'h004;
    @(negedge clk);
    req4 = 1'b0;
    chk("rst4_rom_en", rom_en4, 1);
    @(negedge clk);
    chk("rst4_rom_ack", {ack4, err4}, 2'b10);
    chk("rst4_rom_rdata", rdata4, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("rst4_idle", busy4, 0);

    chk("final_sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_resp_ctrl.md
MEM_RESP_CTRL -- requirements
Module: mem_resp_ctrl

Interface
REQ-001 Parameter DATA_W, 32, width of CPU data and memory data buses.
REQ-002 Parameter ROM_LAT, 1, ROM read latency in cycles from rom_en to valid rom_rdata; legal range 1..15.
REQ-003 Parameter RAM_LAT, 2, RAM read/write latency in cycles from ram_en to completion; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req  input  1  CPU access request, sampled only when busy=0.
REQ-007 we  input  1  1=write, 0=read; sampled with req.
REQ-008 addr  input  12  CPU byte address; sampled with req.
REQ-009 wdata  input  DATA_W  CPU write data; sampled with req.
REQ-010 busy  output  1  access in progress; new req ignored.
REQ-011 ack  output  1  one-cycle completion pulse.
REQ-012 err  output  1  qualifies ack; 1=access refused (write to ROM).
REQ-013 rdata  output  DATA_W  read data, valid when ack=1 and err=0.
REQ-014 rom_en  output  1  one-cycle ROM read strobe.
REQ-015 ram_en  output  1  one-cycle RAM access strobe.
REQ-016 ram_we  output  1  RAM write enable, valid with ram_en.
REQ-017 mem_addr  output  11  latched addr[10:0] to both memories.
REQ-018 mem_wdata  output  DATA_W  latched wdata to RAM.
REQ-019 rom_rdata  input  DATA_W  ROM read data.
REQ-020 ram_rdata  input  DATA_W  RAM read data.

Function
REQ-021 Address map SHALL be: addr[11]=1 -> RAM, addr[11]=0 -> ROM; full 12-bit space decoded, no unmapped region.
REQ-022 FSM SHALL have states IDLE, ROM_ACC, RAM_ACC, RESP.
REQ-023 IDLE with req=1 SHALL latch addr/we/wdata, set busy on the next cycle, and go to RAM_ACC (RAM), ROM_ACC (ROM read), or RESP with err=1 (ROM write).
REQ-024 Entry cycle of ROM_ACC/RAM_ACC SHALL assert rom_en/ram_en for exactly one cycle; ram_we=latched we in that cycle, 0 otherwise.
REQ-025 A 4-bit wait counter SHALL load LAT-1 on entry to an ACC state, decrement each cycle, exit to RESP at zero.
REQ-026 On leaving ACC, rdata SHALL be registered from rom_rdata or ram_rdata per latched region; RAM write leaves rdata unchanged.
REQ-027 RESP SHALL last one cycle with ack=1, then return to IDLE; busy=0 in that IDLE cycle.
REQ-028 Latency: accept edge to ack = ROM_LAT+1 cycles (ROM read), RAM_LAT+1 (RAM read/write), 1 (ROM write, err=1).
REQ-029 busy SHALL be 1 from the cycle after accept through the ack cycle inclusive; req during busy SHALL be ignored, not queued.
REQ-030 req held high continuously SHALL produce back-to-back accesses, one accept per IDLE cycle.
REQ-031 err SHALL be 0 whenever ack=0; rom_en and ram_en SHALL never assert in the same cycle.

Reset
REQ-032 rst=1 SHALL force IDLE, busy=0, ack=0, err=0, rom_en=0, ram_en=0, ram_we=0, counter=0, rdata=0, mem_addr=0, mem_wdata=0 at the next edge.
REQ-033 rst asserted mid-access SHALL abort with no ack; first req after rst deassert SHALL be accepted normally.

Structure
REQ-034 State encoding, region decode constant (addr bit 11), and default latencies SHALL live in shared package mem_bus_pkg.
REQ-035 No sub-module; FSM, counter, and data registers are one module.

Verification
REQ-036 ROM read addr=12'h004, rom_rdata=32'hDEAD_BEEF, ROM_LAT=1 -> rom_en 1 cycle, ack 2 cycles after accept, rdata=32'hDEAD_BEEF, err=0.
REQ-037 RAM write addr=12'h810, wdata=32'h1234_5678, RAM_LAT=2 -> ram_en=ram_we=1 one cycle, mem_addr=11'h010, ack 3 cycles after accept.
REQ-038 ROM write addr=12'h020 -> no rom_en/ram_en, ack=1 and err=1 1 cycle after accept.
REQ-039 req held high for RAM read then ROM read -> exactly two acks, second request accepted in IDLE after first ack, requests during busy ignored.
REQ-040 rst pulsed in cycle 2 of RAM read with RAM_LAT=4 -> no ack, all outputs 0 next cycle, next ROM read completes normally.
